// File: rtl/csr_pkg.sv
// Shared definitions for the rv32i machine-mode CSR file and trap controller:
// CSR addresses, csr_op encodings, mstatus bit positions, cause codes and FSM states.
package csr_pkg;

  localparam logic [11:0] CSR_MSTATUS   = 12'h300;
  localparam logic [11:0] CSR_MTVEC     = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
  localparam logic [11:0] CSR_MEPC      = 12'h341;
  localparam logic [11:0] CSR_MCAUSE    = 12'h342;
  localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
  localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
  localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
  localparam logic [11:0] CSR_MINSTRETH = 12'hB82;

  localparam int MSTATUS_MIE  = 3;
  localparam int MSTATUS_MPIE = 7;

  typedef enum logic [1:0] {
    CSR_NONE = 2'b00,
    CSR_RW   = 2'b01,
    CSR_RS   = 2'b10,
    CSR_RC   = 2'b11
  } csr_op_e;

  typedef enum logic [3:0] {
    CAUSE_ILLEGAL = 4'd2,
    CAUSE_EBREAK  = 4'd3,
    CAUSE_ECALL   = 4'd11
  } cause_e;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } state_e;

  // Read-modify-write value for the three Zicsr access flavours.
  function automatic logic [31:0] csr_apply(csr_op_e op, logic [31:0] old, logic [31:0] src);
    case (op)
      CSR_RW:  return src;
      CSR_RS:  return old | src;
      CSR_RC:  return old & ~src;
      default: return old;
    endcase
  endfunction

endpackage

// File: rtl/csr_trap_unit_if.sv
// Datapath <-> CSR/trap unit bundle: CSR access, exception/mret requests, PC redirect.
interface csr_trap_unit_if #(parameter int PC_W = 16);

  logic            csr_en;
  logic [1:0]      csr_op;
  logic            csr_imm;
  logic [11:0]     csr_addr;
  logic [4:0]      rs1_field;
  logic [31:0]     rs1_data;
  logic [31:0]     csr_rdata;
  logic            illegal_csr;
  logic            exc_valid;
  logic [3:0]      exc_cause;
  logic [PC_W-1:0] exc_pc;
  logic            mret;
  logic            instret;
  logic            redirect_valid;
  logic [PC_W-1:0] redirect_pc;

  modport master (
    output csr_en, csr_op, csr_imm, csr_addr, rs1_field, rs1_data,
    output exc_valid, exc_cause, exc_pc, mret, instret,
    input  csr_rdata, illegal_csr, redirect_valid, redirect_pc
  );

  modport slave (
    input  csr_en, csr_op, csr_imm, csr_addr, rs1_field, rs1_data,
    input  exc_valid, exc_cause, exc_pc, mret, instret,
    output csr_rdata, illegal_csr, redirect_valid, redirect_pc
  );

endinterface

// File: rtl/csr_counter64.sv
// 64-bit free-running event counter with enable and a 32-bit lo/hi read port.
module csr_counter64 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic        sel_hi,
  output logic [31:0] rdata
);

  logic [63:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (en) begin
      count <= count + 64'd1;
    end
  end

  assign rdata = sel_hi ? count[63:32] : count[31:0];

endmodule

// File: rtl/csr_trap_unit.sv
// Machine-mode CSR file and trap controller for the rv32i core.
// Define CSR_COUNTERS_EN to add read-only mcycle/minstret (0xB00/0xB80, 0xB02/0xB82).
module csr_trap_unit
  import csr_pkg::*;
#(
  parameter int              PC_W        = 16,
  parameter logic [PC_W-1:0] RESET_MTVEC = 16'h0100
) (
  input logic           clk,
  input logic           rst_n,
  csr_trap_unit_if.slave bus
);

  localparam logic [PC_W-1:0] ALIGN_MASK = {{(PC_W-2){1'b1}}, 2'b00};

  state_e          state;
  logic            redirect_valid_q;
  logic [PC_W-1:0] redirect_pc_q;
  logic [PC_W-1:0] mtvec;
  logic [PC_W-1:0] mepc;
  logic [31:0]     mscratch;
  logic [3:0]      mcause;
  logic            mie;
  logic            mpie;

  csr_op_e     op;
  logic        access;
  logic        impl;
  logic        read_only;
  logic        wants_write;
  logic        do_write;
  logic [31:0] rd_val;
  logic [31:0] src;
  logic [31:0] wr_val;

`ifdef CSR_COUNTERS_EN
  logic [31:0] cycle_rdata;
  logic [31:0] instret_rdata;

  // mcycle is read-only, so no CSR write can ever collide with its increment.
  csr_counter64 u_mcycle (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (1'b1),
    .sel_hi (bus.csr_addr[7]),
    .rdata  (cycle_rdata)
  );

  csr_counter64 u_minstret (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (bus.instret && (state == ST_RUN)),
    .sel_hi (bus.csr_addr[7]),
    .rdata  (instret_rdata)
  );
`else
  logic unused_instret;
  assign unused_instret = bus.instret;
`endif

  // NOTE: every variable assigned in always_comb gets a default first, otherwise a latch is inferred.
  always_comb begin
    rd_val    = '0;
    impl      = 1'b0;
    read_only = 1'b0;
    case (bus.csr_addr)
      CSR_MSTATUS: begin
        impl                 = 1'b1;
        rd_val[MSTATUS_MIE]  = mie;
        rd_val[MSTATUS_MPIE] = mpie;
      end
      CSR_MTVEC: begin
        impl   = 1'b1;
        rd_val = 32'(mtvec);
      end
      CSR_MSCRATCH: begin
        impl   = 1'b1;
        rd_val = mscratch;
      end
      CSR_MEPC: begin
        impl   = 1'b1;
        rd_val = 32'(mepc);
      end
      CSR_MCAUSE: begin
        impl   = 1'b1;
        rd_val = {28'd0, mcause};
      end
`ifdef CSR_COUNTERS_EN
      CSR_MCYCLE, CSR_MCYCLEH: begin
        impl      = 1'b1;
        read_only = 1'b1;
        rd_val    = cycle_rdata;
      end
      CSR_MINSTRET, CSR_MINSTRETH: begin
        impl      = 1'b1;
        read_only = 1'b1;
        rd_val    = instret_rdata;
      end
`endif
      default: ;
    endcase
  end

  // The instruction in flight during FLUSH is squashed, so its access is not seen.
  assign op          = csr_op_e'(bus.csr_op);
  assign access      = bus.csr_en && (op != CSR_NONE) && (state == ST_RUN);
  assign src         = bus.csr_imm ? {27'd0, bus.rs1_field} : bus.rs1_data;
  assign wants_write = (op == CSR_RW) || (bus.rs1_field != 5'd0);
  assign do_write    = access && impl && !read_only && wants_write;
  assign wr_val      = csr_apply(op, rd_val, src);

  assign bus.illegal_csr    = access && (!impl || (read_only && wants_write));
  assign bus.csr_rdata      = (access && impl) ? rd_val : 32'd0;
  assign bus.redirect_valid = redirect_valid_q;
  assign bus.redirect_pc    = redirect_pc_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= ST_RUN;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= '0;
      mtvec            <= RESET_MTVEC;
      mepc             <= '0;
      mscratch         <= '0;
      mcause           <= '0;
      mie              <= 1'b0;
      mpie             <= 1'b0;
    end else if (state == ST_FLUSH) begin
      state            <= ST_RUN;
      redirect_valid_q <= 1'b0;
    end else if (bus.exc_valid) begin
      mepc             <= bus.exc_pc & ALIGN_MASK;
      mcause           <= bus.exc_cause;
      mpie             <= mie;
      mie              <= 1'b0;
      redirect_pc_q    <= mtvec;
      redirect_valid_q <= 1'b1;
      state            <= ST_FLUSH;
    end else if (bus.mret) begin
      mie              <= mpie;
      mpie             <= 1'b1;
      redirect_pc_q    <= mepc;
      redirect_valid_q <= 1'b1;
      state            <= ST_FLUSH;
    end else if (do_write) begin
      case (bus.csr_addr)
        CSR_MSTATUS: begin
          mie  <= wr_val[MSTATUS_MIE];
          mpie <= wr_val[MSTATUS_MPIE];
        end
        CSR_MTVEC:    mtvec    <= wr_val[PC_W-1:0] & ALIGN_MASK;
        CSR_MSCRATCH: mscratch <= wr_val;
        CSR_MEPC:     mepc     <= wr_val[PC_W-1:0] & ALIGN_MASK;
        CSR_MCAUSE:   mcause   <= wr_val[3:0];
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_csr_trap_unit.sv
// Scoreboard bench for csr_trap_unit: an architectural CSR model predicts read data,
// illegal flags and redirect targets; a negedge monitor pops and compares them.
module tb_csr_trap_unit;

  localparam int          PC_W        = 16;
  localparam logic [15:0] RESET_MTVEC = 16'h0100;

  bit clk   = 1'b0;
  bit rst_n = 1'b1;
  always #5 clk = ~clk;

  csr_trap_unit_if #(.PC_W(PC_W)) bus ();

  csr_trap_unit #(.PC_W(PC_W), .RESET_MTVEC(RESET_MTVEC)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [31:0] rdata;
    logic        illegal;
  } acc_t;

  acc_t        acc_q[$];
  logic [15:0] redir_q[$];
  int          checks = 0;
  int          errors = 0;

  // Architectural model: CSR values as software sees them, plus a pending-redirect flag.
  bit [31:0] m_csr[bit [11:0]];
  bit        m_flush;
  bit [63:0] m_cycle;
  bit [63:0] m_instret;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit m_impl(bit [11:0] a);
    case (a)
      12'h300, 12'h305, 12'h340, 12'h341, 12'h342: return 1'b1;
`ifdef CSR_COUNTERS_EN
      12'hB00, 12'hB02, 12'hB80, 12'hB82: return 1'b1;
`endif
      default: return 1'b0;
    endcase
  endfunction

  function automatic bit m_ro(bit [11:0] a);
    return a[11:8] == 4'hB;
  endfunction

  function automatic bit [31:0] m_wmask(bit [11:0] a);
    case (a)
      12'h300: return 32'h0000_0088;
      12'h305: return 32'h0000_FFFC;
      12'h340: return 32'hFFFF_FFFF;
      12'h341: return 32'h0000_FFFC;
      12'h342: return 32'h0000_000F;
      default: return 32'h0;
    endcase
  endfunction

  function automatic bit [31:0] m_read(bit [11:0] a);
    case (a)
      12'hB00: return m_cycle[31:0];
      12'hB80: return m_cycle[63:32];
      12'hB02: return m_instret[31:0];
      12'hB82: return m_instret[63:32];
      default: return m_csr[a];
    endcase
  endfunction

  function automatic void model_reset();
    m_csr[12'h300] = 0;
    m_csr[12'h305] = {16'h0, RESET_MTVEC};
    m_csr[12'h340] = 0;
    m_csr[12'h341] = 0;
    m_csr[12'h342] = 0;
    m_flush        = 1'b0;
    m_cycle        = 0;
    m_instret      = 0;
  endfunction

  function automatic void model_step(bit en, bit [1:0] op, bit imm, bit [11:0] addr, bit [4:0] f,
                                     bit [31:0] d, bit exc, bit [3:0] cause, bit [15:0] pc,
                                     bit mr, bit ir);
    bit        acc;
    bit        impl;
    bit        wr;
    bit        ill;
    bit [31:0] old;
    bit [31:0] src;
    bit [31:0] nv;
    bit [31:0] ms;
    if (m_flush) begin
      m_flush = 1'b0;
      if (en) acc_q.push_back('{rdata: 32'h0, illegal: 1'b0});
      return;
    end
    acc  = en && (op != 2'b00);
    impl = m_impl(addr);
    wr   = (op == 2'b01) || (f != 0);
    old  = (acc && impl) ? m_read(addr) : 32'h0;
    ill  = acc && (!impl || (m_ro(addr) && wr));
    if (en) acc_q.push_back('{rdata: old, illegal: ill});
    if (ir) m_instret++;
    src = imm ? {27'h0, f} : d;
    ms  = m_csr[12'h300];
    if (exc) begin
      m_csr[12'h341] = {16'h0, pc & 16'hFFFC};
      m_csr[12'h342] = {28'h0, cause};
      m_csr[12'h300] = ms[3] ? 32'h80 : 32'h0;
      redir_q.push_back(m_csr[12'h305][15:0]);
      m_flush = 1'b1;
    end else if (mr) begin
      m_csr[12'h300] = 32'h80 | (ms[7] ? 32'h8 : 32'h0);
      redir_q.push_back(m_csr[12'h341][15:0]);
      m_flush = 1'b1;
    end else if (acc && impl && !m_ro(addr) && wr) begin
      case (op)
        2'b01:   nv = src;
        2'b10:   nv = old | src;
        default: nv = old & ~src;
      endcase
      m_csr[addr] = nv & m_wmask(addr);
    end
  endfunction

  task automatic step(input bit en, input bit [1:0] op, input bit imm, input bit [11:0] addr,
                      input bit [4:0] f, input bit [31:0] d, input bit exc, input bit [3:0] cause,
                      input bit [15:0] pc, input bit mr, input bit ir);
    bus.csr_en    = en;
    bus.csr_op    = op;
    bus.csr_imm   = imm;
    bus.csr_addr  = addr;
    bus.rs1_field = f;
    bus.rs1_data  = d;
    bus.exc_valid = exc;
    bus.exc_cause = cause;
    bus.exc_pc    = pc;
    bus.mret      = mr;
    bus.instret   = ir;
    model_step(en, op, imm, addr, f, d, exc, cause, pc, mr, ir);
    @(posedge clk);
    if (rst_n) m_cycle++;
    #1;
  endtask

  task automatic csr(input bit [1:0] op, input bit imm, input bit [11:0] addr,
                     input bit [4:0] f, input bit [31:0] d);
    step(1'b1, op, imm, addr, f, d, 1'b0, 4'd0, 16'h0, 1'b0, 1'b1);
  endtask

  task automatic rd(input bit [11:0] addr);
    csr(2'b10, 1'b0, addr, 5'd0, 32'h0);
  endtask

  // Everything driven while the redirect is pending must be dropped.
  task automatic junk();
    step(1'b1, 2'b01, 1'b0, 12'h340, 5'd1, 32'hDEAD_BEEF, 1'b1, 4'd11, 16'h0F0F, 1'b1, 1'b1);
  endtask

  task automatic reset_now();
    step_clear();
    rst_n = 1'b0;
    #1;
    check("reset_redirect_valid", 32'(bus.redirect_valid), 32'h0);
    check("reset_redirect_pc", 32'(bus.redirect_pc), 32'h0);
    acc_q.delete();
    redir_q.delete();
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic step_clear();
    bus.csr_en    = 1'b0;
    bus.csr_op    = 2'b00;
    bus.csr_imm   = 1'b0;
    bus.csr_addr  = 12'h0;
    bus.rs1_field = 5'd0;
    bus.rs1_data  = 32'h0;
    bus.exc_valid = 1'b0;
    bus.exc_cause = 4'd0;
    bus.exc_pc    = 16'h0;
    bus.mret      = 1'b0;
    bus.instret   = 1'b0;
  endtask

  // Monitor: compares whatever the DUT presents against the oldest expectation.
  initial begin
    acc_t e;
    forever begin
      @(negedge clk);
      if (rst_n && bus.csr_en) begin
        if (acc_q.size() == 0) begin
          check("unexpected_access", 32'(bus.csr_rdata), 32'hFFFF_FFFF);
        end else begin
          e = acc_q.pop_front();
          check("csr_rdata", bus.csr_rdata, e.rdata);
          check("illegal_csr", 32'(bus.illegal_csr), 32'(e.illegal));
        end
      end
      if (rst_n && bus.redirect_valid) begin
        if (redir_q.size() == 0) begin
          check("unexpected_redirect", 32'(bus.redirect_pc), 32'hFFFF_FFFF);
        end else begin
          check("redirect_pc", 32'(bus.redirect_pc), 32'(redir_q.pop_front()));
        end
      end
    end
  end

  initial begin
    bit [11:0] addrs[11];
    bit [3:0]  causes[3];
    addrs  = '{12'h300, 12'h305, 12'h340, 12'h341, 12'h342, 12'hB00, 12'hB02, 12'hB80,
               12'hB82, 12'h005, 12'h344};
    causes = '{4'd2, 4'd3, 4'd11};
    step_clear();
    #1;
    reset_now();

    rd(12'h305);
    rd(12'h300);
    csr(2'b01, 1'b0, 12'h305, 5'd1, 32'h56);
    rd(12'h305);
    csr(2'b01, 1'b0, 12'h305, 5'd1, 32'h100);

    csr(2'b10, 1'b1, 12'h300, 5'd8, 32'h0);
    rd(12'h300);
    csr(2'b11, 1'b1, 12'h300, 5'd8, 32'h0);
    rd(12'h300);
    rd(12'hB00);

    csr(2'b10, 1'b1, 12'h300, 5'd8, 32'h0);
    step(1'b0, 2'b00, 1'b0, 12'h0, 5'd0, 32'h0, 1'b1, 4'd11, 16'h0024, 1'b0, 1'b1);
    junk();
    rd(12'h341);
    rd(12'h342);
    rd(12'h300);

    csr(2'b01, 1'b0, 12'h341, 5'd1, 32'h28);
    step(1'b0, 2'b00, 1'b0, 12'h0, 5'd0, 32'h0, 1'b0, 4'd0, 16'h0, 1'b1, 1'b1);
    junk();
    rd(12'h300);
    rd(12'h341);

    csr(2'b01, 1'b0, 12'hB00, 5'd1, 32'h5);
    csr(2'b01, 1'b0, 12'h005, 5'd1, 32'h5);
    csr(2'b01, 1'b0, 12'h340, 5'd1, 32'h1234_5678);
    csr(2'b11, 1'b0, 12'hB82, 5'd3, 32'h1);
    rd(12'h340);

    step(1'b1, 2'b01, 1'b0, 12'h340, 5'd1, 32'h0, 1'b1, 4'd3, 16'h0046, 1'b1, 1'b0);
    junk();
    rd(12'h341);
    rd(12'h340);

    step(1'b0, 2'b00, 1'b0, 12'h0, 5'd0, 32'h0, 1'b1, 4'd2, 16'h0080, 1'b0, 1'b0);
    reset_now();
    rd(12'h305);
    rd(12'h300);
    rd(12'h341);

    for (int i = 0; i < 1500; i++) begin
      bit [4:0] f;
      bit       exc;
      f   = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
      exc = ($urandom_range(0, 11) == 0);
      step(($urandom_range(0, 9) < 7), 2'($urandom), 1'($urandom), addrs[$urandom_range(0, 10)],
           f, $urandom, exc, causes[$urandom_range(0, 2)], 16'($urandom),
           ($urandom_range(0, 11) == 0), 1'($urandom));
    end

    step_clear();
    repeat (3) step(1'b0, 2'b00, 1'b0, 12'h0, 5'd0, 32'h0, 1'b0, 4'd0, 16'h0, 1'b0, 1'b0);
    check("access_queue_drained", 32'(acc_q.size()), 32'h0);
    check("redirect_queue_drained", 32'(redir_q.size()), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/csr_trap_unit.md
Name: csr_trap_unit

Overview:
- Machine-mode CSR file and trap controller for the rv32i core.
- Answers the datapath's CSR accesses: csrrw, csrrs and csrrc, plus their immediate forms.
- Takes exception entry and mret requests from the datapath.
- Returns a registered one-cycle PC redirect to the fetch stage.

Parameters:
- PC_W, 16, width of the program counter and of mepc/mtvec storage (zero-extended to 32 on read).
- RESET_MTVEC, 16'h0100, reset value of the trap vector base.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- csr_en  in  1  CSR instruction in the current cycle.
- csr_op  in  2  2'b01 RW, 2'b10 RS, 2'b11 RC; equals funct3[1:0]. 2'b00 is treated as no access.
- csr_imm  in  1  1: source operand is zero-extended rs1_field; 0: source is rs1_data.
- csr_addr  in  12  CSR address, instr[31:20].
- rs1_field  in  5  instr[19:15]; serves as the rs1 index or zimm.
- rs1_data  in  32  register-file rs1 value.
- csr_rdata  out  32  old CSR value, written to rd by the datapath.
- illegal_csr  out  1  combinational flag: access is unimplemented, or is a write to a read-only CSR.
- exc_valid  in  1  exception raised by the current instruction.
- exc_cause  in  4  mcause code: 2 illegal instruction, 3 ebreak, 11 ecall.
- exc_pc  in  PC_W  PC of the faulting instruction.
- mret  in  1  mret executing.
- instret  in  1  an instruction retired this cycle.
- redirect_valid  out  1  one-cycle pulse, registered.
- redirect_pc  out  PC_W  target PC; valid while redirect_valid is high.

Behaviour:
- Implemented CSRs:
  - mstatus 0x300: only MIE (bit 3) and MPIE (bit 7) are stored; all other bits read 0.
  - mtvec 0x305: direct mode only; bits [1:0] read 0.
  - mscratch 0x340.
  - mepc 0x341: bits [1:0] read 0.
  - mcause 0x342: bit 31 reads 0; bits [3:0] are stored.
  - Read-only: mcycle 0xB00/mcycleh 0xB80 and minstret 0xB02/minstreth 0xB82 (see Optional Feature).
- Read path is combinational. csr_rdata is the pre-write value in the same cycle. When there is no access or the address is unimplemented, csr_rdata = 0.
- Write timing: the write lands at the next rising edge.
  - RW: new = src.
  - RS: new = old | src.
  - RC: new = old & ~src.
- RS/RC with rs1_field == 0 perform no write and raise no illegal flag, even on a read-only CSR.
- RW to a read-only CSR, or any access to an unimplemented address: illegal_csr = 1 and no state changes. The datapath converts this to exc_valid with cause 2 in the following cycle.
- Exception entry (exc_valid):
  - mepc <= exc_pc & ~3.
  - mcause <= exc_cause.
  - MPIE <= MIE.
  - MIE <= 0.
  - Next cycle: redirect_valid = 1, redirect_pc = mtvec.
- mret: MIE <= MPIE, MPIE <= 1. Next cycle: redirect_valid = 1, redirect_pc = mepc.
- Priority within one cycle: exc_valid > mret > CSR write. A lower-priority request is dropped entirely.
- Two-state controller:
  - RUN to FLUSH on exception or mret.
  - FLUSH to RUN unconditionally after one cycle.
  - redirect_valid = (state == FLUSH).
  - In FLUSH, csr_en, exc_valid, mret and instret are ignored, because the instruction in flight is being squashed.
- Reset (asynchronous, rst_n low):
  - state = RUN, redirect_valid = 0, redirect_pc = 0.
  - mtvec = RESET_MTVEC; all other CSRs = 0.
  - A reset during FLUSH aborts the redirect immediately.
- A write to mepc in the same cycle as an mret cannot occur, since mret wins; an mret therefore always uses the registered mepc.

Optional Feature:
- Macro: CSR_COUNTERS_EN.
- Defined:
  - 64-bit mcycle increments every cycle, except in the cycle of a CSR write to it, which is illegal anyway.
  - 64-bit minstret increments when instret is high and state is RUN.
  - Both wrap 2^64-1 to 0.
  - Low/high halves are readable at the addresses above.
- Undefined: those four addresses are unimplemented and follow the illegal rules; no counter flops are synthesised.

Decomposition:
- Package csr_pkg:
  - CSR address constants.
  - csr_op encodings.
  - mstatus bit indices MIE=3, MPIE=7.
  - Cause codes.
  - State encoding.
- Sub-module csr_counter64: enable plus synchronous increment, 32-bit lo/hi read mux. Instanced twice under CSR_COUNTERS_EN.

Test Plan:
- Reset: rst_n low mid-FLUSH → redirect_valid drops at once; read 0x305 returns 0x00000100 and 0x300 returns 0.
- RW mtvec: csrrw x0, 0x305, rs1_data=0x56 → next-cycle read returns 0x54. Same-cycle csr_rdata returns the old value 0x100.
- csrrsi mstatus zimm=8, then csrrci zimm=8 → reads 0x8, then 0x0. csrrs with rs1_field=0 on mcycle → no illegal flag, no write.
- Exception: MIE=1, exc_valid, cause=11, exc_pc=0x0024 → next cycle redirect_valid=1, redirect_pc=0x0100. mepc reads 0x24, mcause reads 11, mstatus reads 0x80.
- mret after the exception: mepc updated by software to 0x28 → redirect_pc=0x0028, mstatus reads 0x88. Inputs driven in the FLUSH cycle are ignored.
- Illegal/priority: RW to 0xB00, or access to 0x005 → illegal_csr=1, no state change. exc_valid and mret together → exception path taken. With CSR_COUNTERS_EN, mcycle lo 0xFFFFFFFF rolls over into hi.
